// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and state encoding for the fetch unit (HOLD exists only with FETCH_BUF_EN)
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
`ifdef FETCH_BUF_EN
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_e;
`else
  typedef enum logic [1:0] {FETCH, DRAIN} state_e;
`endif
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: one-entry inst/pc4 holding register with load and clear, present only with FETCH_BUF_EN
`ifdef FETCH_BUF_EN
module fetch_buf
  import fetch_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] pc4_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc4_o
);
  logic [XLEN-1:0] inst_q, inst_d, pc4_q, pc4_d;
  always_comb begin
    inst_d = clear_i ? NOP : load_i ? inst_i : inst_q;
    pc4_d  = clear_i ? NOP : load_i ? pc4_i : pc4_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      inst_q <= NOP;
      pc4_q  <= NOP;
    end else begin
      inst_q <= inst_d;
      pc4_q  <= pc4_d;
    end
  end
  assign inst_o = inst_q;
  assign pc4_o  = pc4_q;
endmodule
`endif

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with one outstanding request, redirect drain and optional stall buffer (FETCH_BUF_EN)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_addr_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_addr_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_data_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc4_o,
  output logic            valid_o
);
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, drain_q, drain_d, pc_next, target;
  logic redirect;
`ifdef FETCH_BUF_EN
  logic buf_load, buf_clear;
  logic [XLEN-1:0] buf_inst, buf_pc4;
  fetch_buf u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .inst_i  (imem_data_i),
    .pc4_i   (pc_next),
    .inst_o  (buf_inst),
    .pc4_o   (buf_pc4)
  );
`endif
  assign redirect = jump_i | branch_i;
  assign target   = jump_i ? jump_addr_i : branch_addr_i;
  assign pc_next  = pc_q + PC_STEP;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drain_d     = drain_q;
    imem_req_o  = 1'b0;
    imem_addr_o = NOP;
    valid_o     = 1'b0;
    inst_o      = NOP;
    pc4_o       = NOP;
`ifdef FETCH_BUF_EN
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_q;
        valid_o     = imem_ack_i & ~redirect;
        inst_o      = valid_o ? imem_data_i : NOP;
        pc4_o       = valid_o ? pc_next : NOP;
        if (imem_ack_i) begin
          if (redirect) pc_d = target;
          else if (!stall_i) pc_d = pc_next;
`ifdef FETCH_BUF_EN
          else begin
            buf_load = 1'b1;
            pc_d     = pc_next;
            state_d  = HOLD;
          end
`endif
        end else if (redirect) begin
          drain_d = pc_q;
          pc_d    = target;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        imem_req_o  = 1'b1;
        imem_addr_o = drain_q;
        if (imem_ack_i) state_d = FETCH;
        if (redirect) pc_d = target;
      end
`ifdef FETCH_BUF_EN
      HOLD: begin
        valid_o = 1'b1;
        inst_o  = buf_inst;
        pc4_o   = buf_pc4;
        if (redirect) begin
          buf_clear = 1'b1;
          pc_d      = target;
          state_d   = FETCH;
        end else if (!stall_i) state_d = FETCH;
      end
`endif
      default: state_d = FETCH;
    endcase
    if (!rst_i) begin
      imem_req_o  = 1'b0;
      imem_addr_o = NOP;
      valid_o     = 1'b0;
      inst_o      = NOP;
      pc4_o       = NOP;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      drain_q <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus random stimulus checked against a behavioural fetch model
module tb_fetch_unit;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0, branch_i = 1'b0, jump_i = 1'b0, imem_ack_i = 1'b0;
  logic [31:0] branch_addr_i = '0, jump_addr_i = '0, imem_data_i = '0;
  logic        imem_req_o, valid_o;
  logic [31:0] imem_addr_o, inst_o, pc4_o;
  int checks = 0, failures = 0;
  logic [31:0] m_pc, m_drain_addr, m_held_inst, m_held_pc4;
  bit          m_draining, m_held;
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc4;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .inst_o(inst_o), .pc4_o(pc4_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model
  task automatic step(input bit r, input bit st, input bit br, input logic [31:0] ba,
                      input bit j, input logic [31:0] ja, input bit ak);
    bit e_req, e_valid, redir, ack;
    logic [31:0] e_addr, e_inst, e_pc4, tgt;
    @(negedge clk_i);
    redir = br | j;
    tgt = j ? ja : ba;
    e_req = r && !m_held;
    e_addr = m_draining ? m_drain_addr : m_pc;
    ack = ak && e_req;
    rst_i = r; stall_i = st; branch_i = br; branch_addr_i = ba; jump_i = j; jump_addr_i = ja;
    imem_ack_i = ack;
    imem_data_i = ack ? mem_word(e_addr) : $urandom;
    e_valid = 1'b0; e_inst = 32'h0; e_pc4 = 32'h0;
    if (r && m_held) begin
      e_valid = 1'b1; e_inst = m_held_inst; e_pc4 = m_held_pc4;
    end else if (r && !m_draining && ack && !redir) begin
      e_valid = 1'b1; e_inst = mem_word(m_pc); e_pc4 = m_pc + 32'd4;
    end
    #1;
    obs_req = imem_req_o; obs_valid = valid_o; obs_addr = imem_addr_o; obs_pc4 = pc4_o;
    check("req", {31'b0, imem_req_o}, {31'b0, e_req});
    check("valid", {31'b0, valid_o}, {31'b0, e_valid});
    check("inst", inst_o, e_inst);
    check("pc4", pc4_o, e_pc4);
    if (e_req) check("addr", imem_addr_o, e_addr);
    @(posedge clk_i);
    if (!r) begin
      m_pc = 32'h0; m_held = 0; m_draining = 0;
    end else if (m_held) begin
      if (redir) begin m_held = 0; m_pc = tgt; end
      else if (!st) m_held = 0;
    end else if (m_draining) begin
      if (ack) m_draining = 0;
      if (redir) m_pc = tgt;
    end else if (ack) begin
      if (redir) m_pc = tgt;
      else if (!st) m_pc = m_pc + 32'd4;
`ifdef FETCH_BUF_EN
      else begin
        m_held = 1; m_held_inst = mem_word(m_pc); m_held_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
      end
`endif
    end else if (redir) begin
      m_draining = 1; m_drain_addr = m_pc; m_pc = tgt;
    end
  endtask

  task automatic go(input bit ak);
    step(1, 0, 0, 0, 0, 0, ak);
  endtask

  task automatic jmp(input logic [31:0] a, input bit ak);
    step(1, 0, 0, 0, 1, a, ak);
  endtask

  initial begin
    m_pc = 0; m_held = 0; m_draining = 0; m_drain_addr = 0; m_held_inst = 0; m_held_pc4 = 0;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      go(1);
      check("seq_addr", obs_addr, 32'(4 * i));
      check("seq_pc4", obs_pc4, 32'(4 * i + 4));
    end
    go(1);
    for (int i = 0; i < 3; i++) begin
      go(0);
      check("wait_addr", obs_addr, 32'h10);
    end
    go(1);
    check("wait_ack_addr", obs_addr, 32'h10);
    check("wait_ack_pc4", obs_pc4, 32'h14);
    jmp(32'h20, 1);
    jmp(32'h200, 0);
    check("drain_first", obs_addr, 32'h20);
    go(0);
    check("drain_hold", obs_addr, 32'h20);
    go(1);
    check("drain_valid", {31'b0, obs_valid}, 32'h0);
    go(1);
    check("jump_target", obs_addr, 32'h200);
    step(1, 0, 1, 32'h100, 1, 32'h300, 1);
    go(1);
    check("jump_wins", obs_addr, 32'h300);
    jmp(32'h40, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    check("stall_pc4", obs_pc4, 32'h44);
    step(1, 1, 0, 0, 0, 0, 1);
`ifdef FETCH_BUF_EN
    check("stall_hold_req", {31'b0, obs_req}, 32'h0);
`else
    check("stall_refetch", obs_addr, 32'h40);
`endif
    step(1, 0, 0, 0, 0, 0, 1);
    check("stall_release_valid", {31'b0, obs_valid}, 32'h1);
`ifndef FETCH_BUF_EN
    check("stall_release_addr", obs_addr, 32'h40);
`endif
    go(1);
    check("after_stall", obs_addr, 32'h44);
    jmp(32'h80, 1);
    go(0);
    check("rst_pre", obs_addr, 32'h80);
    step(0, 0, 0, 0, 0, 0, 1);
    check("rst_req", {31'b0, obs_req}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    go(0);
    check("rst_first", obs_addr, 32'h0);
    jmp(32'hFFFF_FFFC, 1);
    go(1);
    check("wrap_pc4", obs_pc4, 32'h0);
    go(1);
    check("wrap_addr", obs_addr, 32'h0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(49) != 0, $urandom_range(2) == 0, $urandom_range(7) == 0,
           $urandom & 32'hFFFF_FFFC, $urandom_range(9) == 0, $urandom & 32'hFFFF_FFFC,
           $urandom_range(1) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk_i  input  1  clock, all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-low.
REQ-004 stall_i  input  1  downstream hold (hazard detect or IF/ID stall); instruction not consumed.
REQ-005 branch_i  input  1  taken branch redirect from decode.
REQ-006 branch_addr_i  input  32  branch target.
REQ-007 jump_i  input  1  jump redirect from decode.
REQ-008 jump_addr_i  input  32  jump target.
REQ-009 imem_req_o  output  1  instruction memory request.
REQ-010 imem_addr_o  output  32  request address, word aligned.
REQ-011 imem_ack_i  input  1  memory ack; imem_data_i valid only in the ack cycle.
REQ-012 imem_data_i  input  32  fetched instruction.
REQ-013 inst_o  output  32  instruction presented to IF/ID register.
REQ-014 pc4_o  output  32  address of inst_o plus 4, feeds IF/ID data input.
REQ-015 valid_o  output  1  inst_o/pc4_o valid this cycle; low means IF/ID captures a bubble.

Function
REQ-016 State register pc (32 b) plus FSM states FETCH, HOLD, DRAIN; one outstanding memory request maximum.
REQ-017 Redirect = jump_i | branch_i; target = jump_addr_i when jump_i, else branch_addr_i (jump wins); redirect overrides stall_i.
REQ-018 Memory protocol: imem_req_o held high with stable imem_addr_o until the ack cycle; ack in the same cycle as the first req cycle (zero wait) is legal.
REQ-019 FETCH: imem_req_o=1, imem_addr_o=pc; valid_o = imem_ack_i & ~redirect; inst_o=imem_data_i; pc4_o=pc+4.
REQ-020 FETCH, ack, redirect: fetched word discarded, pc<=target, stay FETCH.
REQ-021 FETCH, ack, no redirect, ~stall_i: consumed, pc<=pc+4, stay FETCH.
REQ-022 FETCH, ack, no redirect, stall_i: behaviour per REQ-031/REQ-032.
REQ-023 FETCH, no ack, redirect: latch pc into drain address, pc<=target, go DRAIN.
REQ-024 FETCH, no ack, no redirect: stay FETCH, request held.
REQ-025 DRAIN: imem_req_o=1 on drain address, valid_o=0; on ack discard data, go FETCH; redirect in DRAIN updates pc only.
REQ-026 HOLD: imem_req_o=0, valid_o=1, inst_o/pc4_o from buffer; redirect: clear buffer, pc<=target, go FETCH; else ~stall_i: go FETCH; else stay.
REQ-027 pc arithmetic modulo 2^32; pc+4 from 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-028 When valid_o=0, inst_o=32'h0000_0000 (NOP) and pc4_o=32'h0000_0000.

Reset
REQ-029 While rst_i=0 at a clock edge: pc<=RESET_PC, state<=FETCH, buffer cleared; imem_req_o, valid_o, inst_o, pc4_o forced 0 combinationally while rst_i=0.
REQ-030 Reset mid-request drops the outstanding request; memory sees imem_req_o fall, and first post-reset request is RESET_PC.

Configuration
REQ-031 FETCH_BUF_EN defined: one-entry buffer; FETCH+ack+stall_i without redirect stores imem_data_i and pc+4 in buffer, pc<=pc+4, go HOLD.
REQ-032 FETCH_BUF_EN undefined: no buffer, no HOLD state; FETCH+ack+stall_i discards word, pc unchanged, stay FETCH (same address re-fetched next cycle).

Structure
REQ-033 Package fetch_pkg holds state enumeration, NOP constant 32'h0000_0000, instruction/address width 32, PC step 4.
REQ-034 Sub-module fetch_buf (one-entry inst/pc4 holding register with load/clear) instantiated only under FETCH_BUF_EN.

Verification
REQ-035 Reset release, zero-wait memory, stall_i=0 -> addresses 0x0,0x4,0x8 on consecutive cycles; pc4_o 0x4,0x8,0xC; valid_o=1 each cycle.
REQ-036 Ack delayed 3 cycles at pc=0x10 -> imem_addr_o stable 0x10 for 4 cycles, valid_o=0 for 3 cycles then 1 with pc4_o=0x14.
REQ-037 jump_i with jump_addr_i=0x200 while request at 0x20 unacked -> DRAIN until ack, data discarded, next request 0x200, no valid_o for 0x20.
REQ-038 stall_i=1 for 2 cycles on ack at 0x40 -> with FETCH_BUF_EN: valid_o held, inst_o stable, next request 0x44 after release; without: 0x40 re-requested each cycle.
REQ-039 branch_i and jump_i same cycle, targets 0x100/0x300 -> next request 0x300.
REQ-040 rst_i low during WAIT at 0x80 -> imem_req_o=0 during reset, first request after release at RESET_PC.
